// File: rtl/parallel_dot_product_pkg.sv
// parallel_dot_product_pkg: default widths and the requantise/saturate helper
package parallel_dot_product_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF = 32;
  localparam int OUT_W_DEF = 8;
  function automatic logic signed [63:0] requant(input logic signed [63:0] x, input int shift,
                                                 input bit relu, input int out_w);
    logic signed [63:0] v, hi, lo;
    v = (shift > 0) ? x + (64'sd1 <<< (shift - 1)) : x;
    v = v >>> shift;
    if (relu && v < 0) v = '0;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction
endpackage

// File: rtl/parallel_dot_product_lane_adder_tree.sv
// lane_adder_tree: sign-extending sum of all lane products with a registered result
module lane_adder_tree #(
  parameter int LANES = 4,
  parameter int IN_W = 16,
  parameter int OUT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [LANES*IN_W-1:0]    in,
  output logic signed [OUT_W-1:0]  sum
);
  logic signed [OUT_W-1:0] s;
  // combinational sum of every lane, each sign-extended to the result width
  always_comb begin
    s = '0;
    for (int i = 0; i < LANES; i++) s = s + OUT_W'($signed(in[i*IN_W +: IN_W]));
  end
  // register the sum whenever the pipeline advances
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (en) sum <= s;
endmodule

// File: rtl/parallel_dot_product.sv
// parallel_dot_product: 3-stage streaming dot product with accumulate and requantise
module parallel_dot_product
  import parallel_dot_product_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES = 4,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 0,
  parameter int RELU = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sop,
  input  logic                      eop,
  input  logic [LANES*DATA_W-1:0]   data_a,
  input  logic [LANES*DATA_W-1:0]   data_b,
  input  logic [LANES-1:0]          in_keep,
  input  logic signed [ACC_W-1:0]   bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   acc_out,
  output logic signed [OUT_W-1:0]   q_out,
  output logic                      err
);
  localparam int PW = 2 * DATA_W;
  logic adv, fire, frame, v1, s1, e1, v2, s2, e2;
  logic signed [ACC_W-1:0] b1, b2, acc, sum2, acc_next;
  logic signed [OUT_W-1:0] q_next;
  logic signed [PW-1:0] p [LANES];
  logic [LANES*PW-1:0] prod;
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  assign fire = in_valid & adv;
  // full-width signed lane products
  always_comb
    for (int i = 0; i < LANES; i++)
      p[i] = $signed(data_a[i*DATA_W +: DATA_W]) * $signed(data_b[i*DATA_W +: DATA_W]);
  // frame tracking at acceptance: sop-in-frame and orphan beats both flag err, orphans are dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      frame <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= fire & (sop == frame);
      if (fire) frame <= sop ? ~eop : frame & ~eop;
    end
  // stage 1 products and stage 2 flags travel together, all held while stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {v1, s1, e1, v2, s2, e2} <= '0;
      b1 <= '0;
      b2 <= '0;
      prod <= '0;
    end else if (adv) begin
      v1 <= in_valid & (sop | frame);
      s1 <= sop;
      e1 <= eop;
      b1 <= bias;
      for (int i = 0; i < LANES; i++) prod[i*PW +: PW] <= in_keep[i] ? p[i] : '0;
      {v2, s2, e2} <= {v1, s1, e1};
      b2 <= b1;
    end
  lane_adder_tree #(.LANES(LANES), .IN_W(PW), .OUT_W(ACC_W)) u_tree (
    .clk(clk), .rst(rst), .en(adv), .in(prod), .sum(sum2)
  );
  // accumulate and requantise the candidate result
  always_comb begin
    acc_next = s2 ? b2 + sum2 : acc + sum2;
    q_next = OUT_W'(requant(64'(acc_next), SHIFT, RELU != 0, OUT_W));
  end
  // stage 3 accumulator and held output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      out_valid <= 1'b0;
      acc_out <= '0;
      q_out <= '0;
    end else if (adv) begin
      if (v2) acc <= acc_next;
      out_valid <= v2 & e2;
      if (v2 & e2) begin
        acc_out <= acc_next;
        q_out <= q_next;
      end
    end
endmodule

// File: tb/tb_parallel_dot_product.sv
// tb_parallel_dot_product: directed checks of three parameterisations sharing one stimulus
module tb_parallel_dot_product;
  logic clk = 0, rst = 1, in_valid = 0, sop = 0, eop = 0, out_ready = 1;
  logic [31:0] data_a = '0, data_b = '0;
  logic [3:0] in_keep = '0;
  logic signed [31:0] bias = '0;
  logic rdy0, rdy17, rdyr, ov0, ov17, ovr, err0, err17, errr;
  logic signed [31:0] acc0, acc17, accr;
  logic signed [7:0] q0, q17, qr;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  parallel_dot_product #(.SHIFT(0), .RELU(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .sop(sop), .eop(eop),
    .data_a(data_a), .data_b(data_b), .in_keep(in_keep), .bias(bias), .out_valid(ov0),
    .out_ready(out_ready), .acc_out(acc0), .q_out(q0), .err(err0));
  parallel_dot_product #(.SHIFT(17), .RELU(0)) u17 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy17), .sop(sop), .eop(eop),
    .data_a(data_a), .data_b(data_b), .in_keep(in_keep), .bias(bias), .out_valid(ov17),
    .out_ready(out_ready), .acc_out(acc17), .q_out(q17), .err(err17));
  parallel_dot_product #(.SHIFT(0), .RELU(1)) ur (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyr), .sop(sop), .eop(eop),
    .data_a(data_a), .data_b(data_b), .in_keep(in_keep), .bias(bias), .out_valid(ovr),
    .out_ready(out_ready), .acc_out(accr), .q_out(qr), .err(errr));
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic s, input logic e,
                      input logic [3:0] k, input logic signed [31:0] bi);
    data_a = a;
    data_b = b;
    sop = s;
    eop = e;
    in_keep = k;
    bias = bi;
    in_valid = 1;
    step(1);
    in_valid = 0;
  endtask
  initial begin
    #2;
    chk("rst_rdy", rdy0, 1);
    chk("rst_ov", ov0, 0);
    chk("rst_acc", acc0, 0);
    chk("rst_q", q0, 0);
    chk("rst_err", err0, 0);
    step(1);
    rst = 0;
    beat(32'h04030201, 32'h08070605, 1, 1, 4'hF, 0);
    chk("lat_e1", ov0, 0);
    step(1);
    chk("lat_e2", ov0, 0);
    step(1);
    chk("lat_e3", ov0, 1);
    chk("single_acc", acc0, 70);
    chk("single_q", q0, 70);
    step(1);
    chk("single_clear", ov0, 0);
    for (int i = 0; i < 196; i++) beat(32'h7F7F7F7F, 32'h7F7F7F7F, i == 0, i == 195, 4'hF, 0);
    step(1);
    chk("long_pend", ov0, 0);
    step(1);
    chk("long_ov", ov0, 1);
    chk("long_acc", acc0, 12645136);
    chk("long_q_sat", q0, 127);
    chk("long_q_shift17", q17, 96);
    chk("long_q_relu", qr, 127);
    step(1);
    beat(32'hFFFFFFFF, 32'h01010101, 1, 1, 4'hF, 0);
    step(2);
    chk("neg_acc", acc0, -4);
    chk("neg_q", q0, -4);
    chk("neg_acc_relu", accr, -4);
    chk("neg_q_relu", qr, 0);
    step(1);
    beat(32'h04030201, 32'h01010101, 1, 0, 4'hF, 10);
    beat(32'h08070605, 32'h02020202, 0, 1, 4'b0011, 0);
    step(2);
    chk("keep_ov", ov0, 1);
    chk("keep_acc", acc0, 42);
    chk("keep_q", q0, 42);
    step(1);
    beat(32'h09090909, 32'h01010101, 1, 0, 4'hF, 0);
    chk("sop_ok_err", err0, 0);
    beat(32'h01010101, 32'h01010101, 1, 0, 4'hF, 5);
    chk("resop_err", err0, 1);
    beat(32'h01010101, 32'h01010101, 0, 1, 4'hF, 0);
    chk("resop_err_pulse", err0, 0);
    step(2);
    chk("resop_ov", ov0, 1);
    chk("resop_acc", acc0, 13);
    step(1);
    beat(32'h01010101, 32'h01010101, 0, 1, 4'hF, 0);
    chk("orphan_err", err0, 1);
    step(1);
    chk("orphan_err_pulse", err0, 0);
    step(2);
    chk("orphan_no_out", ov0, 0);
    chk("orphan_acc_held", acc0, 13);
    out_ready = 0;
    beat(32'h01010101, 32'h01010101, 1, 1, 4'hF, 0);
    beat(32'h02020202, 32'h03030303, 1, 1, 4'hF, 0);
    step(1);
    chk("bp_ov", ov0, 1);
    chk("bp_acc", acc0, 4);
    chk("bp_rdy", rdy0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_hold_ov", ov0, 1);
      chk("bp_hold_acc", acc0, 4);
      chk("bp_hold_rdy", rdy0, 0);
    end
    out_ready = 1;
    #1;
    chk("bp_release_rdy", rdy0, 1);
    step(1);
    chk("bp_second_ov", ov0, 1);
    chk("bp_second_acc", acc0, 24);
    step(1);
    chk("bp_done", ov0, 0);
    beat(32'h05050505, 32'h05050505, 1, 0, 4'hF, 0);
    beat(32'h05050505, 32'h05050505, 0, 0, 4'hF, 0);
    rst = 1;
    #1;
    chk("midrst_ov", ov0, 0);
    chk("midrst_acc", acc0, 0);
    chk("midrst_q", q0, 0);
    chk("midrst_err", err0, 0);
    chk("midrst_rdy", rdy0, 1);
    @(posedge clk);
    #1;
    rst = 0;
    chk("postrst_rdy", rdy0, 1);
    beat(32'h01010101, 32'h01010101, 0, 1, 4'hF, 0);
    chk("postrst_orphan_err", err0, 1);
    beat(32'h01010101, 32'h02020202, 1, 0, 4'hF, 0);
    beat(32'h01010101, 32'h01010101, 0, 1, 4'hF, 0);
    step(2);
    chk("postrst_ov", ov0, 1);
    chk("postrst_acc", acc0, 12);
    chk("postrst_q", q0, 12);
    chk("postrst_q17", q17, 0);
    step(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
